muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the pipelined CPU's EX stage.
//  Successor to the fixed 32-bit unit. Adds WIDTH/latency parameters, an iterative radix-2 divider,
//  maddu/msub/msubu, a done pulse and a divide-by-zero flag.
//  The CPU stalls any HI/LO consumer while busy=1.
// PARAMETERS
//  WIDTH    32  operand and HI/LO width; legal range 8..64
//  MUL_LAT  3   multiply-class latency in cycles; legal range 1..8
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      qualifies op/a/b; sampled only when busy=0
//  op        in   4      0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo,
//                        1000 madd, 1001 maddu, 1010 msub, 1011 msubu; other codes are no-ops
//  a         in   WIDTH  operand A (dividend; mthi/mtlo source)
//  b         in   WIDTH  operand B (divisor)
//  abort     in   1      cancel in-flight op; port exists only when MDU_ABORT_EN is defined
//  busy      out  1      op in flight
//  done      out  1      1-cycle pulse on the cycle hi/lo take a mult/div result
//  div_zero  out  1      1-cycle pulse when div/divu is started with b==0
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-op): busy=0, done=0, div_zero=0, hi=0, lo=0.
//    The divider and counter are cleared. Operation resumes on the first edge after reset=1.
//  - Acceptance: an op is accepted at edge T0 when start=1 and busy=0.
//    start while busy=1 is ignored; no queueing.
//  - mthi/mtlo: hi<=a or lo<=a at T0. busy stays 0, no done pulse.
//  - Multiply class, L=MUL_LAT:
//    - Operands and current {hi,lo} are captured at T0.
//    - busy=1 from T0 until edge T0+L. At that edge {hi,lo} is written, busy=0, done=1 for one cycle.
//    - mult: signed 2W product. multu: unsigned 2W product.
//    - madd/msub: {hi,lo} +/- signed product. maddu/msubu: {hi,lo} +/- unsigned product.
//    - All results are truncated mod 2^(2W).
//  - Divide class, L=WIDTH+2:
//    - State machine IDLE -> PREP (absolute values) -> ITER (WIDTH shift-subtract steps) -> FIX (sign fix) -> IDLE.
//    - Result is written at T0+L with busy=0 and done=1.
//    - Signed quotient truncates toward zero; remainder takes the dividend's sign. lo=quotient, hi=remainder.
//    - Overflow case: most-negative / -1 gives lo=most-negative, hi=0.
//    - divu uses unsigned operands.
//  - Divide by zero (b==0 at T0): not started. busy stays 0, hi/lo unchanged, div_zero=1 for one cycle, no done.
//  - hi/lo never change while busy=1, except on reset or completion.
//  - done and a new accept may occur back-to-back: start in the cycle where done=1 is accepted.
//  - Unused op codes with start=1: no state change.
// CONFIGURATION
//  - MDU_ABORT_EN defined:
//    - abort port present. abort=1 at an edge while busy=1 gives busy=0 at that edge, hi/lo unchanged, no done.
//    - abort=1 together with start=1 and busy=0 suppresses the start; no div_zero pulse.
//    - Used for exception flush.
//  - MDU_ABORT_EN undefined: no abort port. An op always runs to completion.
// TESTING (WIDTH=32, MUL_LAT=3)
//  1. mult a=0xFFFFFFFD(-3), b=7
//     -> busy high 3 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse.
//  2. div a=0xFFFFFFF9(-7), b=2
//     -> busy 34 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0xF.
//  3. mthi a=0x1234; mtlo a=0; then madd a=2, b=3 -> hi=0x1234, lo=6.
//     Then msubu a=1, b=7 -> hi=0x1233, lo=0xFFFFFFFF.
//  4. div a=5, b=0 -> div_zero 1-cycle pulse, busy=0, hi/lo unchanged, no done.
//     div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5. Start divu, pulse reset=0 after 10 cycles
//     -> busy=0, hi=lo=0 immediately, no done.
//     Start mult while busy -> ignored.
//  6. [MDU_ABORT_EN] abort at cycle 5 of div
//     -> busy=0 next edge, hi/lo unchanged, no done.
//     start+abort together -> nothing accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with a fixed-latency multiplier and a radix-2 restoring divider.
// Define MDU_ABORT_EN to add the abort (pipeline flush) input.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, MUL, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             done_d, div_zero_d;
  logic             abort_i;
  logic             sgn;
  logic [W2-1:0]    ext_a, ext_b, prod, mul_res;
  logic [WIDTH:0]   shifted, diff;

`ifdef MDU_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // mode_q = {accumulate, subtract, unsigned}; opa/opb hold operands, later |dividend|->quotient and |divisor|
  assign sgn     = ~mode_q[0];
  assign ext_a   = {{WIDTH{sgn & opa_q[WIDTH-1]}}, opa_q};
  assign ext_b   = {{WIDTH{sgn & opb_q[WIDTH-1]}}, opb_q};
  assign prod    = ext_a * ext_b;
  assign mul_res = mode_q[2] ? (mode_q[1] ? acc_q - prod : acc_q + prod) : prod;
  assign shifted = {rem_q, opa_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort_i) begin
            case (op)
              4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                state_d = MUL;
                cnt_d   = CW'(MUL_LAT - 1);
                mode_d  = {op[3], op[1], op[0]};
                opa_d   = a;
                opb_d   = b;
                acc_d   = {hi, lo};
              end
              4'b0010, 4'b0011: begin
                if (b == '0) begin
                  div_zero_d = 1'b1;
                end else begin
                  state_d = PREP;
                  mode_d  = {op[3], op[1], op[0]};
                  opa_d   = a;
                  opb_d   = b;
                end
              end
              4'b0100: hi_d = a;
              4'b0101: lo_d = a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            {hi_d, lo_d} = mul_res;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        PREP: begin
          qneg_d  = sgn & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
          rneg_d  = sgn & opa_q[WIDTH-1];
          opa_d   = (sgn && opa_q[WIDTH-1]) ? {WIDTH{1'b0}} - opa_q : opa_q;
          opb_d   = (sgn && opb_q[WIDTH-1]) ? {WIDTH{1'b0}} - opb_q : opb_q;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ITER;
        end
        ITER: begin
          // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
          opa_d = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          if (cnt_q == '0) state_d = FIX;
          else cnt_d = cnt_q - CW'(1);
        end
        FIX: begin
          lo_d    = qneg_q ? {WIDTH{1'b0}} - opa_q : opa_q;
          hi_d    = rneg_q ? {WIDTH{1'b0}} - rem_q : rem_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi       <= hi_d;
      lo       <= lo_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end
endmodule
